register_bank: RTL and testbench

//   Parametrised multi-register bank; successor to the single 32-bit load-enabled register.

---
 rtl/register_bank.sv | 92 +++++++++
 tb/tb_register_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// General register file: DEPTH x WIDTH registers, one byte-masked write port,
// two read ports with optional hardwired R0, write forwarding and registered reads.
module register_bank #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               R0_ZERO   = 1'b1,
  parameter bit               BYPASS    = 1'b1,
  parameter bit               REG_READ  = 1'b0,
  localparam int unsigned     AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned     BE        = WIDTH / 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [BE-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  if ((WIDTH % 8 != 0) || (DEPTH < 2) || (DEPTH > 256)) begin : g_cfg_err
    $error("register_bank: WIDTH must be a multiple of 8 and DEPTH in 2..256");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok_c;
  logic             fwd_ok_c;
  logic [WIDTH-1:0] wr_merged_c;
  logic [WIDTH-1:0] read_a_c;
  logic [WIDTH-1:0] read_b_c;

  // Indices past DEPTH exist when DEPTH is not a power of two.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return ({1'b0, addr} < (AW+1)'(DEPTH));
  endfunction

  function automatic logic is_r0(input logic [AW-1:0] addr);
    return R0_ZERO && (addr == '0);
  endfunction

  // Stored word with the enabled byte lanes replaced by the incoming data.
  always_comb begin
    wr_merged_c = mem[wr_addr];
    for (int i = 0; i < BE; i++) begin
      if (wr_be[i]) wr_merged_c[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  assign wr_ok_c  = wr_en && addr_ok(wr_addr) && !is_r0(wr_addr);
  assign fwd_ok_c = BYPASS && wr_ok_c && clear;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mem <= '{default: RESET_VAL};
    end else if (wr_ok_c) begin
      mem[wr_addr] <= wr_merged_c;
    end
  end

  // Read value: zero for R0/out-of-range, forwarded word on address match.
  always_comb begin
    read_a_c = mem[rd_addr_a];
    if (fwd_ok_c && (wr_addr == rd_addr_a)) read_a_c = wr_merged_c;
    if (!addr_ok(rd_addr_a) || is_r0(rd_addr_a)) read_a_c = '0;
  end

  always_comb begin
    read_b_c = mem[rd_addr_b];
    if (fwd_ok_c && (wr_addr == rd_addr_b)) read_b_c = wr_merged_c;
    if (!addr_ok(rd_addr_b) || is_r0(rd_addr_b)) read_b_c = '0;
  end

  if (REG_READ) begin : g_reg_read
    always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
        rd_data_a <= '0;
        rd_data_b <= '0;
      end else begin
        rd_data_a <= read_a_c;
        rd_data_b <= read_b_c;
      end
    end
  end else begin : g_comb_read
    assign rd_data_a = read_a_c;
    assign rd_data_b = read_b_c;
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: a default instance (u0) and a DEPTH=12, R0 writable,
// no-bypass, registered-read instance (u1) share stimulus; each has its own reference.
module tb_register_bank;

  localparam logic [31:0] RV1 = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        clear;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] a0, b0, a1, b1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m0 [16];
  logic [31:0] m1 [12];
  logic [31:0] q1a, q1b;

  always #5 clk = ~clk;

  register_bank u0 (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(a0),
    .rd_addr_b(rd_addr_b), .rd_data_b(b0)
  );

  register_bank #(
    .DEPTH(12), .RESET_VAL(RV1), .R0_ZERO(1'b0), .BYPASS(1'b0), .REG_READ(1'b1)
  ) u1 (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(a1),
    .rd_addr_b(rd_addr_b), .rd_data_b(b1)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // u0: R0 reads zero, same-cycle writes forwarded.
  function automatic logic [31:0] ref0(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
    if (clear && wr_en && wr_addr == a) return merge(m0[a], wr_be, wr_data);
    return m0[a];
  endfunction

  // u1: only 12 registers, R0 ordinary, old value on same-cycle write.
  function automatic logic [31:0] ref1(input logic [3:0] a);
    if (a >= 4'd12) return 32'h0;
    return m1[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m0[r] = 32'h0;
    for (int r = 0; r < 12; r++) m1[r] = RV1;
    q1a = 32'h0;
    q1b = 32'h0;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic check_all();
    chk("u0_rd_a", a0, ref0(rd_addr_a));
    chk("u0_rd_b", b0, ref0(rd_addr_b));
    chk("u1_rd_a", a1, q1a);
    chk("u1_rd_b", b1, q1b);
  endtask

  // Advance one clock edge and update both references the way the edge should.
  task automatic tick();
    @(posedge clk);
    if (clear) begin
      q1a = ref1(rd_addr_a);
      q1b = ref1(rd_addr_b);
      if (wr_en) begin
        if (wr_addr != 4'd0) m0[wr_addr] = merge(m0[wr_addr], wr_be, wr_data);
        if (wr_addr < 4'd12) m1[wr_addr] = merge(m1[wr_addr], wr_be, wr_data);
      end
    end else begin
      q1a = 32'h0;
      q1b = 32'h0;
    end
    #1;
  endtask

  task automatic step(input logic we, input logic [3:0] wa, input logic [3:0] be,
                      input logic [31:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    drive(we, wa, be, wd, ra, rb);
    #2;
    check_all();
    tick();
  endtask

  initial begin
    clear = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 32'h0, 4'd0, 4'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    chk("reset_u0_r0", a0, 32'h0);
    chk("reset_u1_forced", a1, 32'h0);
    clear = 1'b1;
    #1;
    drive(1'b0, 4'd0, 4'd0, 32'h0, 4'd4, 4'd11);
    #1;
    check_all();
    tick();

    // Fill R1..R15, then asynchronous clear mid-cycle.
    for (int r = 1; r < 16; r++) step(1'b1, 4'(r), 4'hF, 32'hFFFF_FFFF, 4'(r), 4'(r - 1));
    drive(1'b0, 4'd0, 4'd0, 32'h0, 4'd1, 4'd15);
    #2;
    check_all();
    clear = 1'b0;
    #1;
    chk("async_clear_u0_a", a0, 32'h0);
    chk("async_clear_u0_b", b0, 32'h0);
    chk("async_clear_u1_a", a1, 32'h0);
    chk("async_clear_u1_b", b1, 32'h0);
    model_reset();
    drive(1'b1, 4'd2, 4'hF, 32'h0000_0077, 4'd2, 4'd2);
    tick();
    wr_en = 1'b0;
    #1;
    clear = 1'b1;
    #1;
    check_all();
    tick();
    step(1'b0, 4'd0, 4'd0, 32'h0, 4'd2, 4'd1);
    chk("lost_write_u1", a1, RV1);

    // Byte-masked write.
    step(1'b1, 4'd3, 4'hF, 32'h1122_3344, 4'd3, 4'd3);
    step(1'b1, 4'd3, 4'b0101, 32'hAABB_CCDD, 4'd3, 4'd3);
    drive(1'b0, 4'd0, 4'd0, 32'h0, 4'd3, 4'd3);
    #2;
    check_all();
    chk("byte_mask_u0", a0, 32'h11BB_33DD);
    tick();
    chk("byte_mask_u1", a1, 32'h11BB_33DD);

    // R0 hardwired on u0, ordinary on u1.
    drive(1'b1, 4'd0, 4'hF, 32'hDEAD_BEEF, 4'd0, 4'd0);
    #2;
    check_all();
    chk("r0_zero_bypass_u0", a0, 32'h0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 32'h0, 4'd0, 4'd0);
    #2;
    check_all();
    chk("r0_zero_u0", a0, 32'h0);
    tick();
    chk("r0_writable_u1", a1, 32'hDEAD_BEEF);

    // Same-cycle write forwarding.
    step(1'b1, 4'd5, 4'hF, 32'h0, 4'd5, 4'd5);
    drive(1'b1, 4'd5, 4'hF, 32'h1234_5678, 4'd5, 4'd5);
    #2;
    check_all();
    chk("bypass_u0_a", a0, 32'h1234_5678);
    chk("bypass_u0_b", b0, 32'h1234_5678);
    tick();
    chk("no_bypass_u1_a", a1, 32'h0);
    chk("no_bypass_u1_b", b1, 32'h0);

    // Registered read pipeline on u1.
    step(1'b1, 4'd1, 4'hF, 32'h10, 4'd0, 4'd0);
    step(1'b1, 4'd2, 4'hF, 32'h20, 4'd0, 4'd0);
    step(1'b1, 4'd3, 4'hF, 32'h30, 4'd0, 4'd0);
    step(1'b0, 4'd0, 4'd0, 32'h0, 4'd1, 4'd0);
    chk("reg_read_1", a1, 32'h10);
    step(1'b0, 4'd0, 4'd0, 32'h0, 4'd2, 4'd0);
    chk("reg_read_2", a1, 32'h20);
    step(1'b0, 4'd0, 4'd0, 32'h0, 4'd3, 4'd0);
    chk("reg_read_3", a1, 32'h30);

    // Out-of-range address on u1.
    step(1'b1, 4'd13, 4'hF, 32'h55, 4'd13, 4'd13);
    step(1'b0, 4'd0, 4'd0, 32'h0, 4'd13, 4'd11);
    chk("oob_read_u1", a1, 32'h0);
    for (int r = 0; r < 12; r++) step(1'b0, 4'd0, 4'd0, 32'h0, 4'(r), 4'(11 - r));

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wa, ra, rb;
      wa = 4'($urandom_range(15));
      ra = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
      rb = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
      step(1'($urandom_range(1)), wa, 4'($urandom_range(15)), $urandom, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
